// File: rtl/bcnn_job_sequencer_if.sv
// Host-side bundle between the job sequencer, its input/result streams,
// the BCNN engine run/busy port and the shared SRAM host port.
interface bcnn_job_sequencer_if;
  // Streams use valid/ready: a word moves on a cycle where valid and ready are
  // both 1; valid never waits on ready and the payload is held until that cycle.
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        dut_run;
  logic        dut_busy;
  logic        host_sram_write_enable;
  logic [11:0] host_sram_write_address;
  logic [15:0] host_sram_write_data;
  logic [11:0] host_sram_read_address;
  logic [15:0] sram_host_read_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        job_error;

  modport master (
    input  start, in_valid, in_data, dut_busy, sram_host_read_data, res_ready,
    output in_ready, dut_run, host_sram_write_enable, host_sram_write_address,
           host_sram_write_data, host_sram_read_address, res_valid, res_data, job_error
  );

  modport slave (
    output start, in_valid, in_data, dut_busy, sram_host_read_data, res_ready,
    input  in_ready, dut_run, host_sram_write_enable, host_sram_write_address,
           host_sram_write_data, host_sram_read_address, res_valid, res_data, job_error
  );
endinterface

// File: rtl/bcnn_job_sequencer.sv
// Loads input words into SRAM, pulses the BCNN engine, waits out busy, then
// reads the result word back and offers it on the result stream.
module bcnn_job_sequencer #(
  parameter int          NUM_IN   = 1,
  parameter logic [11:0] IN_BASE  = 12'd0,
  parameter logic [11:0] RES_ADDR = 12'd0,
  parameter int          SETTLE   = 2,
  parameter int          TIMEOUT  = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  bcnn_job_sequencer_if.master       bus,
  output logic [3:0]                 dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RUN, S_RUN_WAIT, S_BUSY_WAIT, S_SETTLE, S_READ, S_CAPT, S_RESP
  } state_t;

  localparam logic [11:0] CNT_LAST = 12'(NUM_IN - 1);
  localparam logic [15:0] TMAX     = 16'(TIMEOUT - 1);
  localparam logic [15:0] SMAX     = 16'(SETTLE - 1);

  state_t      state, state_d;
  logic [11:0] cnt, cnt_d;
  logic [15:0] timer, timer_d;
  logic        wr_en, wr_en_d;
  logic [11:0] wr_addr, wr_addr_d;
  logic [15:0] wr_data, wr_data_d;
  logic        run_q, run_d;
  logic [11:0] rd_addr, rd_addr_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_data_q, res_data_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 12'd0;
      timer       <= 16'd0;
      wr_en       <= 1'b0;
      wr_addr     <= 12'd0;
      wr_data     <= 16'd0;
      run_q       <= 1'b0;
      rd_addr     <= 12'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      timer       <= timer_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      run_q       <= run_d;
      rd_addr     <= rd_addr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    timer_d     = timer;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    run_d       = 1'b0;
    rd_addr_d   = 12'd0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          cnt_d   = 12'd0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = IN_BASE + cnt;
          wr_data_d = bus.in_data;
          cnt_d     = cnt + 12'd1;
          if (cnt == CNT_LAST) state_d = S_RUN;
        end
      end
      // The last input write is on the SRAM port this cycle; run follows it.
      S_RUN: begin
        run_d   = 1'b1;
        timer_d = 16'd0;
        state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        timer_d = timer + 16'd1;
        if (bus.dut_busy) begin
          state_d = S_BUSY_WAIT;
        end else if (timer >= TMAX) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_BUSY_WAIT: begin
        timer_d = timer + 16'd1;
        if (!bus.dut_busy) begin
          state_d = S_SETTLE;
          timer_d = 16'd0;
        end else if (timer >= TMAX) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_SETTLE: begin
        timer_d = timer + 16'd1;
        if (timer >= SMAX) begin
          state_d   = S_READ;
          rd_addr_d = RES_ADDR;
        end
      end
      // Address is on the port during READ; the SRAM returns data one cycle on.
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        res_data_d  = bus.sram_host_read_data;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready                = (state == S_LOAD);
  assign bus.dut_run                 = run_q;
  assign bus.host_sram_write_enable  = wr_en;
  assign bus.host_sram_write_address = wr_addr;
  assign bus.host_sram_write_data    = wr_data;
  assign bus.host_sram_read_address  = rd_addr;
  assign bus.res_valid               = res_valid_q;
  assign bus.res_data                = res_data_q;
  assign bus.job_error               = err_q;
  assign dbg_state                   = state;

endmodule

// File: tb/tb_bcnn_job_sequencer.sv
// Bench for bcnn_job_sequencer: SRAM and engine stubs, directed scenarios,
// then randomized jobs checked against a window/popcount reference.
module tb_bcnn_job_sequencer;

  localparam int          NUM_IN   = 4;
  localparam logic [11:0] IN_BASE  = 12'hFFE;
  localparam logic [11:0] RES_ADDR = 12'h010;
  localparam int          SETTLE   = 2;
  localparam int          TIMEOUT  = 15;
  // start-sample edge to res_valid, busy of one cycle, no input gaps
  localparam int          LAT_EXP  = 7 + SETTLE + NUM_IN - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] dbg_state;
  bcnn_job_sequencer_if bus ();

  bcnn_job_sequencer #(
    .NUM_IN(NUM_IN), .IN_BASE(IN_BASE), .RES_ADDR(RES_ADDR),
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine output bit (r,c) is 1 when at least 5 of the 9 window cells agree with the weights.
  function automatic logic [15:0] bcnn_ref(input logic [15:0] m, input logic [8:0] w);
    logic [15:0] r;
    int agree;
    r = 16'h0;
    for (int orow = 0; orow < 2; orow++) begin
      for (int ocol = 0; ocol < 2; ocol++) begin
        agree = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (m[(orow + i) * 4 + ocol + j] == w[i * 3 + j]) agree++;
        r[orow * 2 + ocol] = (agree >= 5);
      end
    end
    return r;
  endfunction

  // ---------------- SRAM + engine stub ----------------
  logic [15:0] mem [4096];
  logic [8:0]  weights  = 9'h1FF;
  int          busy_len = 1;
  bit          hang     = 1'b0;
  int          busy_left = 0;
  logic        eng_busy = 1'b0;
  logic        eng_fell = 1'b0;
  logic        eng_wr   = 1'b0;
  logic [15:0] eng_word = 16'h0;
  logic [15:0] rd_q     = 16'h0;

  assign bus.dut_busy            = eng_busy;
  assign bus.sram_host_read_data = rd_q;

  always @(posedge clk) begin
    eng_fell <= 1'b0;
    eng_wr   <= eng_fell;
    if (bus.dut_run) begin
      eng_word  <= mem[IN_BASE];
      eng_busy  <= 1'b1;
      busy_left <= busy_len;
    end else if (eng_busy && !hang) begin
      if (busy_left <= 1) begin
        eng_busy <= 1'b0;
        eng_fell <= 1'b1;
      end else begin
        busy_left <= busy_left - 1;
      end
    end
    if (eng_wr) mem[RES_ADDR] <= bcnn_ref(eng_word, weights);
    if (bus.host_sram_write_enable) mem[bus.host_sram_write_address] <= bus.host_sram_write_data;
    rd_q <= mem[bus.host_sram_read_address];
  end

  // ---------------- scoreboard / monitor ----------------
  logic [27:0] exp_q[$];
  int   run_cnt  = 0;
  int   res_seen = 0;
  int   rd_seen  = 0;
  logic prev_run = 1'b0;

  always @(negedge clk) begin
    if (bus.host_sram_write_enable) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("write_addr_data", {bus.host_sram_write_address, bus.host_sram_write_data}, exp_q.pop_front());
    end
    if (bus.dut_run) begin
      run_cnt <= run_cnt + 1;
      chk("run_after_last_write", bus.host_sram_write_enable, 1'b0);
      chk("run_single_cycle", prev_run, 1'b0);
    end
    prev_run <= bus.dut_run;
    if (bus.res_valid) res_seen <= res_seen + 1;
    if (bus.host_sram_read_address != 12'd0) rd_seen <= rd_seen + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string p);
    chk({p, "_in_ready"},  bus.in_ready, 0);
    chk({p, "_dut_run"},   bus.dut_run, 0);
    chk({p, "_wr_en"},     bus.host_sram_write_enable, 0);
    chk({p, "_wr_addr"},   bus.host_sram_write_address, 0);
    chk({p, "_wr_data"},   bus.host_sram_write_data, 0);
    chk({p, "_rd_addr"},   bus.host_sram_read_address, 0);
    chk({p, "_res_valid"}, bus.res_valid, 0);
    chk({p, "_res_data"},  bus.res_data, 0);
    chk({p, "_job_error"}, bus.job_error, 0);
  endtask

  task automatic load_job(input logic [15:0] w [4], input bit gappy, output int t_start);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t_start = cyc;
    chk("in_ready_load", bus.in_ready, 1);
    for (int k = 0; k < NUM_IN; k++) begin
      if (gappy) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w[k];
      exp_q.push_back({IN_BASE + 12'(k), w[k]});
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;
  endtask

  task automatic finish_job(input int stall, input bit pulse_start,
                            output logic [15:0] res, output int t_valid);
    int n;
    n = 0;
    bus.res_ready = 1'b0;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("res_valid_seen", bus.res_valid, 1);
    t_valid = cyc;
    res = bus.res_data;
    for (int s = 0; s < stall; s++) begin
      bus.start = pulse_start && (s == 2);
      tick();
      chk("res_valid_hold", bus.res_valid, 1);
      chk("res_data_hold", bus.res_data, res);
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", bus.res_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] w [4];
    logic [15:0] res;
    int t0, t1, runs0, seen0, rd0, n;

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.res_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    reset = 1'b0;
    tick();
    chk("idle_in_ready", bus.in_ready, 0);

    // all-ones matrix, all-ones weights, one-cycle busy
    w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    runs0 = run_cnt;
    load_job(w, 1'b0, t0);
    finish_job(0, 1'b0, res, t1);
    chk("t1_result", res, 16'h000F);
    chk("t1_latency", t1 - t0, LAT_EXP);
    chk("t1_runs", run_cnt - runs0, 1);
    chk("t1_job_error", bus.job_error, 0);

    // all-zeros matrix
    w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    load_job(w, 1'b0, t0);
    finish_job(0, 1'b0, res, t1);
    chk("t2_result", res, 16'h0000);
    chk("t2_latency", t1 - t0, LAT_EXP);
    chk("t2_job_error", bus.job_error, 0);

    // gapped input stream; addresses wrap past 0xFFF
    foreach (w[i]) w[i] = 16'($urandom);
    load_job(w, 1'b1, t0);
    finish_job(0, 1'b0, res, t1);
    chk("t3_result", res, bcnn_ref(w[0], weights));
    chk("t3_writes_done", exp_q.size(), 0);

    // engine stuck busy
    hang = 1'b1;
    seen0 = res_seen; rd0 = rd_seen;
    foreach (w[i]) w[i] = 16'($urandom);
    load_job(w, 1'b0, t0);
    n = 0;
    while (!bus.job_error && n < 100) begin
      tick();
      n++;
    end
    chk("t4_job_error", bus.job_error, 1);
    chk("t4_timeout_cycles", cyc - t0, NUM_IN + 1 + TIMEOUT);
    repeat (5) tick();
    chk("t4_no_res_valid", res_seen - seen0, 0);
    chk("t4_no_read", rd_seen - rd0, 0);
    chk("t4_idle", bus.in_ready, 0);
    hang = 1'b0;
    repeat (10) tick();
    foreach (w[i]) w[i] = 16'($urandom);
    load_job(w, 1'b0, t0);
    chk("t4_error_cleared", bus.job_error, 0);
    finish_job(0, 1'b0, res, t1);
    chk("t4_next_result", res, bcnn_ref(w[0], weights));

    // consumer stalls with a stray start
    runs0 = run_cnt;
    foreach (w[i]) w[i] = 16'($urandom);
    load_job(w, 1'b0, t0);
    finish_job(5, 1'b1, res, t1);
    chk("t5_result", res, bcnn_ref(w[0], weights));
    tick();
    chk("t5_start_ignored", bus.in_ready, 0);
    repeat (3) tick();
    chk("t5_runs", run_cnt - runs0, 1);

    // asynchronous reset while the engine is busy
    busy_len = 8;
    runs0 = run_cnt;
    foreach (w[i]) w[i] = 16'($urandom);
    load_job(w, 1'b0, t0);
    n = 0;
    while (!bus.dut_busy && n < 20) begin
      tick();
      n++;
    end
    chk("t6_busy_seen", bus.dut_busy, 1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) tick();
    chk("t6_no_run_after_reset", run_cnt - runs0, 1);
    busy_len = 1;
    weights = 9'h1FF;
    w = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_job(w, 1'b0, t0);
    finish_job(0, 1'b0, res, t1);
    chk("t6_clean_result", res, 16'h000F);
    chk("t6_clean_latency", t1 - t0, LAT_EXP);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      weights  = 9'($urandom);
      busy_len = $urandom_range(1, 4);
      foreach (w[i]) w[i] = 16'($urandom);
      runs0 = run_cnt;
      load_job(w, 1'($urandom_range(0, 1)), t0);
      finish_job($urandom_range(0, 3), 1'b0, res, t1);
      chk("rand_result", res, bcnn_ref(w[0], weights));
      chk("rand_job_error", bus.job_error, 0);
      tick();
      chk("rand_runs", run_cnt - runs0, 1);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
